// File: rtl/nic_defs.sv
// ----------------------------------------------------------------------------
// nic_defs
//   Shared definitions for the NIC transmit path. It holds:
//     - the transmit scheduler state encoding,
//     - the CCI-P batch width constant,
//     - batch-size decode helpers. The transmitter also uses these helpers,
//       so the scheduler and the pop sequencer always agree on batch length.
//   No ports (package).
// ----------------------------------------------------------------------------
package nic_defs;

    // log2 of the largest CCI-P write batch (4 cache lines).
    localparam int LMAX_CCIP_BATCH = 2;

    // CCI-P cache-line length encoding (1, 2 or 4 lines).
    typedef logic [1:0] t_ccip_clLen;
    localparam t_ccip_clLen CCIP_CL_LEN_1 = 2'b00;
    localparam t_ccip_clLen CCIP_CL_LEN_2 = 2'b01;
    localparam t_ccip_clLen CCIP_CL_LEN_4 = 2'b11;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        GRANT     = 2'd1,
        WAIT_DONE = 2'd2
    } TxSchedState;

    // log2 batch size -> number of entries. Encodings above 4 clamp to 4.
    function automatic logic [LMAX_CCIP_BATCH:0] batch_count(
        input logic [LMAX_CCIP_BATCH-1:0] lsize
    );
        logic [LMAX_CCIP_BATCH:0] cnt;
        case (lsize)
            2'd0:    cnt = 3'd1;
            2'd1:    cnt = 3'd2;
            2'd2:    cnt = 3'd4;
            default: cnt = 3'd4;
        endcase
        return cnt;
    endfunction

    // log2 batch size -> CCI-P cl_len field, clamped the same way.
    function automatic t_ccip_clLen batch_cl_len(
        input logic [LMAX_CCIP_BATCH-1:0] lsize
    );
        t_ccip_clLen len;
        case (lsize)
            2'd0:    len = CCIP_CL_LEN_1;
            2'd1:    len = CCIP_CL_LEN_2;
            2'd2:    len = CCIP_CL_LEN_4;
            default: len = CCIP_CL_LEN_4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// ----------------------------------------------------------------------------
// rr_priority_arbiter
//   Combinational round-robin pick over a request vector. Only indices
//   0..last_idx take part. The search starts at rr_ptr and wraps.
//   Ports:
//     req      in   2**ID_W  request per flow
//     rr_ptr   in   ID_W     index with highest priority this cycle
//     last_idx in   ID_W     highest active index (inclusive)
//     pick     out  ID_W     winning index (valid when any=1)
//     any      out  1        at least one active request
// ----------------------------------------------------------------------------
module rr_priority_arbiter #(
    parameter int ID_W = 1
) (
    input  logic [2**ID_W-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic [ID_W-1:0]    last_idx,
    output logic [ID_W-1:0]    pick,
    output logic               any
);

    localparam int N = 2**ID_W;

    logic [N-1:0]   req_m_s;
    logic [N-1:0]   below_s;
    logic [2*N-1:0] dbl_s;

    // Mask inactive flows, then build the double-width search vector.
    // The lower copy has no requests below rr_ptr, so the lowest set bit of
    // the whole vector is the first requester at or after rr_ptr. Bits above
    // last_idx are zero. A wrap modulo N is therefore the same order as a
    // wrap modulo last_idx+1.
    always_comb begin
        req_m_s = '0;
        below_s = '0;
        for (int i = 0; i < N; i++) begin
            req_m_s[i] = req[i] && (ID_W'(i) <= last_idx);
            below_s[i] = (ID_W'(i) < rr_ptr);
        end
        dbl_s = {req_m_s, req_m_s & ~below_s};
        any   = |req_m_s;
    end

    // Priority-encode the lowest set bit. The loop scans downward so the
    // last write wins. Truncating to ID_W folds the upper copy onto 0..N-1.
    always_comb begin
        pick = '0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl_s[i]) begin
                pick = ID_W'(i);
            end else begin
                pick = pick;
            end
        end
    end

endmodule

// File: rtl/ccip_tx_flow_scheduler.sv
// ----------------------------------------------------------------------------
// ccip_tx_flow_scheduler
//   Chooses which tx flow FIFO the CCI-P transmitter pops next and how many
//   entries it pops. The choice is made in one cycle as a round-robin over
//   all active flows. Flows holding a full batch are preferred. A flow with
//   only a partial batch is flushed after FLUSH_TIMEOUT scan cycles without
//   a full batch. New grants are held off while CCI-P c1 is almost-full.
//   Ports:
//     clk, resetn          clock, synchronous active-low reset
//     start                enables new grants (an in-flight grant completes)
//     number_of_flows      index of the last active flow
//     l_tx_batch_size      log2 batch size (3 clamps to 4)
//     ff_fill_in           packed per-flow FIFO fill levels
//     sRx_c1TxAlmFull      CCI-P c1 almost-full
//     grant_valid/ready    grant handshake to the pop sequencer
//     grant_flow_id/len/flush  grant payload, stable while valid
//     batch_done           sequencer finished popping the accepted grant
//     busy                 scheduler is not scanning
//     stat_grants/flushes  wrapping counts of accepted grants / flushes
// ----------------------------------------------------------------------------
module ccip_tx_flow_scheduler
    import nic_defs::*;
#(
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LFILL_WIDTH       = 4,
    parameter int FLUSH_TIMEOUT     = 256,
    parameter int LTIMEOUT          = 16
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   start,
    input  logic [LMAX_NUM_OF_FLOWS-1:0]           number_of_flows,
    input  logic [LMAX_CCIP_BATCH-1:0]             l_tx_batch_size,
    input  logic [(2**LMAX_NUM_OF_FLOWS)*LFILL_WIDTH-1:0] ff_fill_in,
    input  logic                                   sRx_c1TxAlmFull,
    output logic                                   grant_valid,
    input  logic                                   grant_ready,
    output logic [LMAX_NUM_OF_FLOWS-1:0]           grant_flow_id,
    output logic [LMAX_CCIP_BATCH:0]               grant_len,
    output logic                                   grant_flush,
    input  logic                                   batch_done,
    output logic                                   busy,
    output logic [31:0]                            stat_grants,
    output logic [31:0]                            stat_flushes
);

    localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
    // The compare width holds both a fill level and the largest batch count.
    localparam int CMP_W = (LFILL_WIDTH > LMAX_CCIP_BATCH + 1) ? LFILL_WIDTH
                                                                : LMAX_CCIP_BATCH + 1;
    localparam bit FLUSH_EN = (FLUSH_TIMEOUT != 0);
    localparam logic [LTIMEOUT-1:0] FLUSH_LAST =
        FLUSH_EN ? LTIMEOUT'(FLUSH_TIMEOUT - 1) : {LTIMEOUT{1'b0}};

    logic [LMAX_CCIP_BATCH:0]         bsize_s;
    logic [LFILL_WIDTH-1:0]           fill_s [MAX_FLOWS];
    logic [MAX_FLOWS-1:0]             full_req_s;
    logic [MAX_FLOWS-1:0]             nonempty_req_s;
    logic [LMAX_NUM_OF_FLOWS-1:0]     full_pick_s;
    logic [LMAX_NUM_OF_FLOWS-1:0]     ne_pick_s;
    logic                             full_any_s;
    logic                             ne_any_s;
    logic [LMAX_NUM_OF_FLOWS-1:0]     next_ptr_s;
    logic                             flush_due_s;

    TxSchedState                      state_r;
    logic [LMAX_NUM_OF_FLOWS-1:0]     rr_ptr_r;
    logic [LTIMEOUT-1:0]              timeout_cnt_r;
    logic                             grant_valid_r;
    logic [LMAX_NUM_OF_FLOWS-1:0]     grant_flow_id_r;
    logic [LMAX_CCIP_BATCH:0]         grant_len_r;
    logic                             grant_flush_r;
    logic                             busy_r;
    logic [31:0]                      stat_grants_r;
    logic [31:0]                      stat_flushes_r;

    // Split the packed fill bus into one field per flow.
    for (genvar g = 0; g < MAX_FLOWS; g++) begin : g_fill
        assign fill_s[g] = ff_fill_in[g*LFILL_WIDTH +: LFILL_WIDTH];
    end

    // Batch size decode, shared with the transmitter through the package.
    always_comb begin
        bsize_s = batch_count(l_tx_batch_size);
    end

    // Per-flow eligibility. Flows above number_of_flows never request.
    always_comb begin
        full_req_s     = '0;
        nonempty_req_s = '0;
        for (int i = 0; i < MAX_FLOWS; i++) begin
            if (LMAX_NUM_OF_FLOWS'(i) <= number_of_flows) begin
                full_req_s[i]     = (CMP_W'(fill_s[i]) >= CMP_W'(bsize_s));
                nonempty_req_s[i] = (fill_s[i] != {LFILL_WIDTH{1'b0}});
            end else begin
                full_req_s[i]     = 1'b0;
                nonempty_req_s[i] = 1'b0;
            end
        end
    end

    rr_priority_arbiter #(
        .ID_W (LMAX_NUM_OF_FLOWS)
    ) u_full_arb (
        .req      (full_req_s),
        .rr_ptr   (rr_ptr_r),
        .last_idx (number_of_flows),
        .pick     (full_pick_s),
        .any      (full_any_s)
    );

    rr_priority_arbiter #(
        .ID_W (LMAX_NUM_OF_FLOWS)
    ) u_nonempty_arb (
        .req      (nonempty_req_s),
        .rr_ptr   (rr_ptr_r),
        .last_idx (number_of_flows),
        .pick     (ne_pick_s),
        .any      (ne_any_s)
    );

    // Round-robin pointer after the current grant. It wraps past the last
    // active flow, so a single-flow configuration keeps the pointer at 0.
    always_comb begin
        if (grant_flow_id_r >= number_of_flows) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_flow_id_r + LMAX_NUM_OF_FLOWS'(1);
        end
    end

    // The flush condition applies only when no full batch wins the same cycle.
    always_comb begin
        if (FLUSH_EN && (timeout_cnt_r == FLUSH_LAST)) begin
            flush_due_s = start && !sRx_c1TxAlmFull && ne_any_s;
        end else begin
            flush_due_s = 1'b0;
        end
    end

    // Scheduler FSM with registered grant, status and statistics outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r         <= SCAN;
            rr_ptr_r        <= '0;
            timeout_cnt_r   <= '0;
            grant_valid_r   <= 1'b0;
            grant_flow_id_r <= '0;
            grant_len_r     <= '0;
            grant_flush_r   <= 1'b0;
            busy_r          <= 1'b0;
            stat_grants_r   <= 32'd0;
            stat_flushes_r  <= 32'd0;
        end else begin
            case (state_r)
                SCAN: begin
                    if (start && !sRx_c1TxAlmFull && full_any_s) begin
                        grant_valid_r   <= 1'b1;
                        grant_flow_id_r <= full_pick_s;
                        grant_len_r     <= bsize_s;
                        grant_flush_r   <= 1'b0;
                        timeout_cnt_r   <= '0;
                        busy_r          <= 1'b1;
                        state_r         <= GRANT;
                    end else if (flush_due_s) begin
                        grant_valid_r   <= 1'b1;
                        grant_flow_id_r <= ne_pick_s;
                        grant_len_r     <= {{LMAX_CCIP_BATCH{1'b0}}, 1'b1};
                        grant_flush_r   <= 1'b1;
                        timeout_cnt_r   <= '0;
                        busy_r          <= 1'b1;
                        state_r         <= GRANT;
                    end else if (ne_any_s && start) begin
                        // Saturate so a long stall cannot wrap back below the threshold.
                        if (timeout_cnt_r != {LTIMEOUT{1'b1}}) begin
                            timeout_cnt_r <= timeout_cnt_r + LTIMEOUT'(1);
                        end
                    end else begin
                        timeout_cnt_r <= '0;
                    end
                end
                GRANT: begin
                    // The payload stays frozen; almost-full and start were checked at issue.
                    if (grant_ready) begin
                        grant_valid_r <= 1'b0;
                        rr_ptr_r      <= next_ptr_s;
                        stat_grants_r <= stat_grants_r + 32'd1;
                        if (grant_flush_r) begin
                            stat_flushes_r <= stat_flushes_r + 32'd1;
                        end
                        state_r <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Fill levels are stale while popping, so the arbiters are ignored here.
                    if (batch_done) begin
                        busy_r  <= 1'b0;
                        state_r <= SCAN;
                    end
                end
                default: begin
                    grant_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    state_r       <= SCAN;
                end
            endcase
        end
    end

    assign grant_valid   = grant_valid_r;
    assign grant_flow_id = grant_flow_id_r;
    assign grant_len     = grant_len_r;
    assign grant_flush   = grant_flush_r;
    assign busy          = busy_r;
    assign stat_grants   = stat_grants_r;
    assign stat_flushes  = stat_flushes_r;

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ccip_tx_flow_scheduler
//   Directed bench with four flows. It uses two instances that share all
//   inputs: one flushes after 8 scan cycles, the other has flushing
//   disabled. Every expected value below is worked out by hand.
// ----------------------------------------------------------------------------
module tb_ccip_tx_flow_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  number_of_flows;
    logic [1:0]  l_tx_batch_size;
    logic [15:0] ff_fill_in;
    logic        alm_full;
    logic        grant_ready;
    logic        batch_done;

    logic        grant_valid, grant_flush, busy;
    logic [1:0]  grant_flow_id;
    logic [2:0]  grant_len;
    logic [31:0] stat_grants, stat_flushes;

    logic        nf_grant_valid, nf_grant_flush, nf_busy;
    logic [1:0]  nf_grant_flow_id;
    logic [2:0]  nf_grant_len;
    logic [31:0] nf_stat_grants, nf_stat_flushes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ccip_tx_flow_scheduler #(
        .LMAX_NUM_OF_FLOWS (2), .LFILL_WIDTH (4), .FLUSH_TIMEOUT (8), .LTIMEOUT (16)
    ) dut (
        .clk (clk), .resetn (resetn), .start (start),
        .number_of_flows (number_of_flows), .l_tx_batch_size (l_tx_batch_size),
        .ff_fill_in (ff_fill_in), .sRx_c1TxAlmFull (alm_full),
        .grant_valid (grant_valid), .grant_ready (grant_ready),
        .grant_flow_id (grant_flow_id), .grant_len (grant_len),
        .grant_flush (grant_flush), .batch_done (batch_done), .busy (busy),
        .stat_grants (stat_grants), .stat_flushes (stat_flushes)
    );

    ccip_tx_flow_scheduler #(
        .LMAX_NUM_OF_FLOWS (2), .LFILL_WIDTH (4), .FLUSH_TIMEOUT (0), .LTIMEOUT (16)
    ) dut_nf (
        .clk (clk), .resetn (resetn), .start (start),
        .number_of_flows (number_of_flows), .l_tx_batch_size (l_tx_batch_size),
        .ff_fill_in (ff_fill_in), .sRx_c1TxAlmFull (alm_full),
        .grant_valid (nf_grant_valid), .grant_ready (grant_ready),
        .grant_flow_id (nf_grant_flow_id), .grant_len (nf_grant_len),
        .grant_flush (nf_grant_flush), .batch_done (batch_done), .busy (nf_busy),
        .stat_grants (nf_stat_grants), .stat_flushes (nf_stat_flushes)
    );

    function automatic logic [15:0] mk_fill(input logic [3:0] f0, input logic [3:0] f1,
                                            input logic [3:0] f2, input logic [3:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int limit, output int n);
        n = 0;
        while (grant_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        int nf_seen;
        resetn          = 1'b0;
        start           = 1'b0;
        number_of_flows = 2'd3;
        l_tx_batch_size = 2'd1;
        ff_fill_in      = 16'd0;
        alm_full        = 1'b0;
        grant_ready     = 1'b0;
        batch_done      = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(grant_flow_id), 32'd0);
        chk("rst_len", 32'(grant_len), 32'd0);
        chk("rst_stats", stat_grants | stat_flushes, 32'd0);

        // Batch 2, fills {0,3,2,0}: flow 1 first, then flow 2.
        resetn     = 1'b1;
        ff_fill_in = mk_fill(4'd0, 4'd3, 4'd2, 4'd0);
        start      = 1'b1;
        tick();
        chk("t1_valid", 32'(grant_valid), 32'd1);
        chk("t1_id", 32'(grant_flow_id), 32'd1);
        chk("t1_len", 32'(grant_len), 32'd2);
        chk("t1_flush", 32'(grant_flush), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        chk("t1_ack_valid", 32'(grant_valid), 32'd0);
        chk("t1_ack_busy", 32'(busy), 32'd1);
        chk("t1_ack_stat", stat_grants, 32'd1);
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        chk("t1_done_busy", 32'(busy), 32'd0);
        tick();
        chk("t1_g2_valid", 32'(grant_valid), 32'd1);
        chk("t1_g2_id", 32'(grant_flow_id), 32'd2);
        chk("t1_g2_len", 32'(grant_len), 32'd2);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        batch_done  = 1'b1;
        tick();
        batch_done  = 1'b0;

        // All flows at 4, batch 4: order 0,1,2,3,0 and five grants counted.
        start = 1'b0;
        do_reset();
        l_tx_batch_size = 2'd2;
        ff_fill_in      = mk_fill(4'd4, 4'd4, 4'd4, 4'd4);
        start           = 1'b1;
        grant_ready     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(10, n);
            chk("rr_latency", 32'(n), 32'd1);
            chk("rr_id", 32'(grant_flow_id), 32'(k % 4));
            chk("rr_len", 32'(grant_len), 32'd4);
            tick();
            if (k == 4) start = 1'b0;
            tick();
            tick();
            batch_done = 1'b1;
            tick();
            batch_done = 1'b0;
        end
        grant_ready = 1'b0;
        chk("rr_stat_grants", stat_grants, 32'd5);
        chk("rr_stat_flushes", stat_flushes, 32'd0);
        chk("rr_idle_valid", 32'(grant_valid), 32'd0);

        // Flush: flow 2 holds 1 entry with batch 4. The counter goes 0..7 on
        // the first 7 edges, and the 8th edge issues the flush grant.
        do_reset();
        ff_fill_in = mk_fill(4'd0, 4'd0, 4'd1, 4'd0);
        start      = 1'b1;
        wait_grant(50, n);
        chk("fl_latency", 32'(n), 32'd8);
        chk("fl_id", 32'(grant_flow_id), 32'd2);
        chk("fl_len", 32'(grant_len), 32'd1);
        chk("fl_flush", 32'(grant_flush), 32'd1);
        chk("fl_nf_valid", 32'(nf_grant_valid), 32'd0);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        chk("fl_stat_flushes", stat_flushes, 32'd1);
        chk("fl_stat_grants", stat_grants, 32'd1);
        nf_seen = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (nf_grant_valid === 1'b1) nf_seen++;
        end
        chk("nf_no_grant", 32'(nf_seen), 32'd0);
        chk("nf_stat_grants", nf_stat_grants, 32'd0);

        // Almost-full blocks new grants but does not revoke one already offered.
        do_reset();
        alm_full   = 1'b1;
        ff_fill_in = mk_fill(4'd0, 4'd4, 4'd0, 4'd0);
        start      = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("af_block_valid", 32'(grant_valid), 32'd0);
        chk("af_block_busy", 32'(busy), 32'd0);
        alm_full = 1'b0;
        tick();
        chk("af_release_valid", 32'(grant_valid), 32'd1);
        chk("af_release_id", 32'(grant_flow_id), 32'd1);
        alm_full = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("af_hold_valid", 32'(grant_valid), 32'd1);
        chk("af_hold_len", 32'(grant_len), 32'd4);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        alm_full    = 1'b0;
        chk("af_ack_valid", 32'(grant_valid), 32'd0);
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;

        // number_of_flows=1: flow 3 is out of range, flow 0 is granted.
        start = 1'b0;
        do_reset();
        number_of_flows = 2'd1;
        ff_fill_in      = mk_fill(4'd0, 4'd0, 4'd0, 4'd4);
        start           = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        chk("nof_flow3_valid", 32'(grant_valid), 32'd0);
        chk("nof_flow3_busy", 32'(busy), 32'd0);
        ff_fill_in = mk_fill(4'd4, 4'd0, 4'd0, 4'd4);
        tick();
        chk("nof_flow0_valid", 32'(grant_valid), 32'd1);
        chk("nof_flow0_id", 32'(grant_flow_id), 32'd0);

        // Reset during WAIT_DONE, then a stale batch_done pulse.
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        chk("wd_busy", 32'(busy), 32'd1);
        chk("wd_stat", stat_grants, 32'd1);
        start = 1'b0;
        do_reset();
        chk("wd_rst_busy", 32'(busy), 32'd0);
        chk("wd_rst_valid", 32'(grant_valid), 32'd0);
        chk("wd_rst_stats", stat_grants | stat_flushes, 32'd0);
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        chk("wd_stale_busy", 32'(busy), 32'd0);
        chk("wd_stale_valid", 32'(grant_valid), 32'd0);
        start = 1'b1;
        tick();
        chk("wd_regrant_valid", 32'(grant_valid), 32'd1);
        chk("wd_regrant_id", 32'(grant_flow_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
